// File: rtl/cnc_pkg.sv
// Shared types and sizing for the cnc streaming 4-operand compute engine.
package cnc_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OUT_W     = 17;
  localparam int unsigned FRAME_LEN = 4;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_MAC = 2'b01,
    MODE_MAX = 2'b10,
    MODE_MIN = 2'b11
  } mode_e;

  // Operands of one frame in arrival order.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
  } frame_t;

endpackage

// File: rtl/cnc_alu.sv
// Combinational frame operator: sum, dual multiply-accumulate, max or min of four operands.
module cnc_alu
  import cnc_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] d,
  input  mode_e             mode,
  output logic [OUT_W-1:0]  result
);

  logic [DATA_W-1:0] max_ab;
  logic [DATA_W-1:0] max_cd;
  logic [DATA_W-1:0] min_ab;
  logic [DATA_W-1:0] min_cd;

  // Pairwise reduction tree for max/min.
  always_comb begin
    max_ab = (a > b) ? a : b;
    max_cd = (c > d) ? c : d;
    min_ab = (a < b) ? a : b;
    min_cd = (c < d) ? c : d;
  end

  always_comb begin
    result = '0;
    case (mode)
      MODE_SUM: result = OUT_W'(a) + OUT_W'(b) + OUT_W'(c) + OUT_W'(d);
      MODE_MAC: result = OUT_W'(a) * OUT_W'(b) + OUT_W'(c) * OUT_W'(d);
      MODE_MAX: result = OUT_W'((max_ab > max_cd) ? max_ab : max_cd);
      MODE_MIN: result = OUT_W'((min_ab < min_cd) ? min_ab : min_cd);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/cnc.sv
// cnc top: groups the byte stream into 4-operand frames and strobes one result per frame.
module cnc
  import cnc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_en,
  output logic [OUT_W-1:0]  out_data
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  frame_t           frame_q;
  mode_e            mode_q;
  logic             pend_q;
  logic [OUT_W-1:0] result_c;

  // Slot counter; wraps on the operand that completes a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (in_en) begin
      cnt_q <= (cnt_q == LAST_SLOT) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Operand and frame-mode capture, only while in_en so idle-cycle inputs never reach state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= '0;
      mode_q  <= MODE_SUM;
    end else if (in_en) begin
      case (cnt_q)
        CNT_W'(0): begin
          frame_q.a <= in_data;
          mode_q    <= mode_e'(mode);
        end
        CNT_W'(1): frame_q.b <= in_data;
        CNT_W'(2): frame_q.c <= in_data;
        default:   frame_q.d <= in_data;
      endcase
    end
  end

  // Marks a complete frame; the result is taken one edge later from the registered operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= in_en && (cnt_q == LAST_SLOT);
    end
  end

  cnc_alu u_alu (
    .a      (frame_q.a),
    .b      (frame_q.b),
    .c      (frame_q.c),
    .d      (frame_q.d),
    .mode   (mode_q),
    .result (result_c)
  );

  // Result strobe; out_data holds between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_en   <= 1'b0;
      out_data <= '0;
    end else begin
      out_en <= pend_q;
      if (pend_q) begin
        out_data <= result_c;
      end
    end
  end

endmodule

// File: tb/tb_cnc.sv
// Self-checking bench for cnc: directed scenarios then random traffic against a frame-level model.
module tb_cnc;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [1:0]  mode;
  logic [7:0]  in_data;
  logic        out_en;
  logic [16:0] out_data;

  cnc dut (
    .clk      (clk),
    .reset    (reset),
    .in_en    (in_en),
    .mode     (mode),
    .in_data  (in_data),
    .out_en   (out_en),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state: operands collected so far, frame mode, pending result.
  int m_ops[$];
  int m_mode;
  bit m_pend;
  int m_res;
  bit m_rst;
  bit e_en;
  int e_data;

  int cyc = 0;
  int last_op_cyc;
  int strobe_vals[$];
  int strobe_cyc[$];

  function automatic int ref_result(int md, int a, int b, int c, int d);
    int v[4];
    int r;
    v = '{a, b, c, d};
    r = 0;
    case (md)
      0: r = a + b + c + d;
      1: r = a * b + c * d;
      2: begin
        r = v[0];
        foreach (v[i]) if (v[i] > r) r = v[i];
      end
      default: begin
        r = v[0];
        foreach (v[i]) if (v[i] < r) r = v[i];
      end
    endcase
    return r;
  endfunction

  function automatic int qat(int q[$], int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!m_rst) begin
      e_en = m_pend;
      if (m_pend) e_data = m_res;
      m_pend = 1'b0;
      if (in_en) begin
        if (m_ops.size() == 0) m_mode = int'(mode);
        m_ops.push_back(int'(in_data));
        last_op_cyc = cyc;
        if (m_ops.size() == 4) begin
          m_pend = 1'b1;
          m_res  = ref_result(m_mode, m_ops[0], m_ops[1], m_ops[2], m_ops[3]);
          m_ops.delete();
        end
      end
    end
    #1;
    if (out_en) begin
      strobe_vals.push_back(int'(out_data));
      strobe_cyc.push_back(cyc);
    end
    chk("out_en", 32'(out_en), 32'(e_en));
    chk("out_data", 32'(out_data), 32'(e_data));
  endtask

  task automatic drive(bit en, int md, int d);
    in_en   = en;
    mode    = 2'(md);
    in_data = 8'(d);
    step();
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, int'($urandom), int'($urandom));
  endtask

  task automatic frame(int md, int a, int b, int c, int d);
    drive(1'b1, md, a);
    drive(1'b1, md, b);
    drive(1'b1, md, c);
    drive(1'b1, md, d);
  endtask

  task automatic rst_assert();
    reset  = 1'b0;
    m_rst  = 1'b1;
    m_ops.delete();
    m_pend = 1'b0;
    m_mode = 0;
    e_en   = 1'b0;
    e_data = 0;
    #1;
    chk("rst_async_en", 32'(out_en), 32'(0));
    chk("rst_async_data", 32'(out_data), 32'(0));
  endtask

  task automatic rst_release();
    reset = 1'b1;
    m_rst = 1'b0;
  endtask

  task automatic clear_strobes();
    strobe_vals.delete();
    strobe_cyc.delete();
  endtask

  int op_cyc;

  initial begin
    in_en   = 1'b0;
    mode    = 2'b00;
    in_data = 8'd0;
    rst_assert();
    // Reset held 3 cycles with in_en toggling.
    for (int i = 0; i < 3; i++) drive(i[0], 0, 100 + i);
    rst_release();

    // Sum frames.
    clear_strobes();
    frame(0, 10, 20, 30, 40);
    op_cyc = last_op_cyc;
    idle(1);
    chk("sum_count", 32'(strobe_vals.size()), 32'(1));
    chk("sum_val", 32'(qat(strobe_vals, 0)), 32'(100));
    chk("sum_latency", 32'(qat(strobe_cyc, 0) - op_cyc), 32'(1));
    clear_strobes();
    frame(0, 255, 255, 255, 255);
    idle(1);
    chk("sum_max_val", 32'(qat(strobe_vals, 0)), 32'(1020));

    // MAC with gaps and a mode change after the first operand.
    clear_strobes();
    drive(1'b1, 1, 255); idle(2);
    drive(1'b1, 2, 255); idle(2);
    drive(1'b1, 2, 255); idle(2);
    drive(1'b1, 2, 255);
    idle(1);
    chk("mac_count", 32'(strobe_vals.size()), 32'(1));
    chk("mac_val", 32'(qat(strobe_vals, 0)), 32'(130050));

    // Max then min back-to-back.
    clear_strobes();
    frame(2, 3, 200, 7, 199);
    frame(3, 9, 4, 250, 5);
    idle(1);
    chk("maxmin_count", 32'(strobe_vals.size()), 32'(2));
    chk("max_val", 32'(qat(strobe_vals, 0)), 32'(200));
    chk("min_val", 32'(qat(strobe_vals, 1)), 32'(4));
    chk("maxmin_spacing", 32'(qat(strobe_cyc, 1) - qat(strobe_cyc, 0)), 32'(4));

    // Reset mid-frame discards the partial frame.
    clear_strobes();
    drive(1'b1, 0, 1);
    drive(1'b1, 0, 2);
    rst_assert();
    drive(1'b1, 1, 77);
    rst_release();
    frame(0, 5, 6, 7, 8);
    idle(1);
    chk("midrst_count", 32'(strobe_vals.size()), 32'(1));
    chk("midrst_val", 32'(qat(strobe_vals, 0)), 32'(26));

    // Hold: idle cycles keep out_data.
    clear_strobes();
    idle(10);
    chk("hold_count", 32'(strobe_vals.size()), 32'(0));
    chk("hold_val", 32'(out_data), 32'(26));

    // Reset coincident with a pending strobe.
    clear_strobes();
    frame(1, 2, 3, 4, 5);
    rst_assert();
    drive(1'b0, 0, 0);
    drive(1'b1, 0, 9);
    rst_release();
    idle(2);
    chk("pend_rst_count", 32'(strobe_vals.size()), 32'(0));
    chk("pend_rst_val", 32'(out_data), 32'(0));

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 2) begin
        rst_assert();
        drive(1'($urandom), int'($urandom), int'($urandom));
        rst_release();
      end else begin
        drive($urandom_range(99) < 70, int'($urandom), int'($urandom));
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
